pipe_seq_ctrl: RTL and testbench
================================

Name: pipe_seq_ctrl

Overview:
- Sequencing and hazard controller for the 4-stage 8-bit pipeline (IF, ID, EX, WB).
- Drives PC enable/load and IF/ID enable/flush, resolves jumps in ID, and selects the EX-stage forwarding source and the ID register-file bypass.
- Provides a host debug interface: halt, single-step and resume, with drain of in-flight instructions.
- Counts retired instructions.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN before HALTED; range 1-7, counter is 3 bits.
- START_HALTED, 0, 1 = state after reset is HALTED instead of RUN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- host_halt_req  in  1  level; request halt.
- host_step  in  1  pulse; execute one instruction while HALTED.
- host_resume  in  1  pulse; leave HALTED.
- if_pc  in  8  PC of the instruction currently being fetched.
- id_pc  in  8  PC of the IF/ID instruction.
- id_valid  in  1  IF/ID holds a real instruction.
- id_inst  in  8  IF/ID instruction; [7:6] op (00 MOVI, 01 ADDI, 10 HALT, 11 JMP), [5:3] rd, [5:0] jump imm.
- ex_valid, ex_rd[3], ex_regwrite  in  ID/EX stage info.
- wb_valid, wb_rd[3], wb_regwrite  in  EX/WB stage info.
- pc_en  out  1  PC increments this edge.
- pc_load  out  1  PC loads pc_target this edge; overrides pc_en.
- pc_target  out  8  redirect address.
- ifid_en  out  1  IF/ID captures fetched instruction.
- ifid_flush  out  1  IF/ID valid cleared this edge; wins over ifid_en.
- fwd_a  out  1  EX operand A from WB write data.
- id_bypass  out  1  ID read data from WB write data.
- halted  out  1  state == HALTED.
- state  out  2  00 RUN, 01 DRAIN, 10 HALTED, 11 STEP.
- retired  out  16  retired instruction count.

Behaviour:
- Reset (async): state = RUN, or HALTED if START_HALTED; drain_cnt = 0; retired = 0.
- While rst is high: pc_en = 0, pc_load = 0, ifid_en = 0, ifid_flush = 1, fwd_a = 0, id_bypass = 0.
- All control outputs are combinational from state and inputs, valid in the same cycle.
- Decode signals, all qualified by id_valid:
  - jmp = op 11.
  - hlt = op 10.
  - jtgt = {(id_pc+1)[7:6], id_inst[5:0]}, where id_pc+1 wraps mod 256 (id_pc = FF gives 00xxxxxx).
- RUN:
  - Default outputs: pc_en = 1, ifid_en = 1.
  - jmp: pc_load = 1, pc_target = jtgt, ifid_flush = 1. This is a 1-cycle penalty.
  - hlt: pc_load = 1, pc_target = id_pc+1, ifid_flush = 1, go to DRAIN. The HALT instruction itself retires without writing.
  - host_halt_req without jmp/hlt: pc_load = 1, pc_target = if_pc (fetched instruction is discarded and refetched later), ifid_flush = 1, go to DRAIN.
  - jmp together with host_halt_req: jump target wins, go to DRAIN.
  - Entering DRAIN loads drain_cnt = DRAIN_CYCLES-1.
- DRAIN:
  - Outputs: pc_en = 0, ifid_en = 0, ifid_flush = 1.
  - A valid jmp in ID still asserts pc_load with pc_target = jtgt.
  - A valid hlt in ID is ignored.
  - drain_cnt decrements each cycle; when it is 0, go to HALTED.
  - host inputs are ignored.
- HALTED:
  - Outputs: pc_en = 0, ifid_en = 0, ifid_flush = 1.
  - host_resume goes to RUN; it has priority over host_step.
  - host_step goes to STEP.
  - host_halt_req is ignored.
- STEP (exactly 1 cycle):
  - Outputs: pc_en = 1, ifid_en = 1, no flush.
  - Next state is DRAIN with drain_cnt = DRAIN_CYCLES-1.
- Forwarding:
  - fwd_a = ex_valid & wb_valid & wb_regwrite & (wb_rd == ex_rd).
  - id_bypass = id_valid & wb_valid & wb_regwrite & (wb_rd == id_inst[5:3]).
  - Both are active in every state.
- Retire counter:
  - retired increments on each clk edge with wb_valid = 1, in every state.
  - Wraps FFFF to 0000.
- Reset mid-DRAIN or mid-STEP: immediate return to the reset state; counter cleared.

Test Plan:
- Reset with START_HALTED = 0, then release -> state = 00, pc_en = 1, ifid_flush = 0, retired = 0; 4 valid WB cycles give retired = 4.
- RUN, id_valid = 1, id_inst = 8'hC5, id_pc = 8'h7F -> same cycle pc_load = 1, pc_target = 8'h85, ifid_flush = 1; with id_pc = 8'hFF -> pc_target = 8'h05.
- RUN, id_inst = 8'h80, id_pc = 8'h10 -> pc_target = 8'h11, DRAIN for 3 cycles (pc_en = 0), then halted = 1 on the 4th cycle.
- host_halt_req = 1 with if_pc = 8'h22 and no jump in ID -> pc_load = 1, pc_target = 8'h22, DRAIN then HALTED; host_step pulse -> one STEP cycle with pc_en = 1 and ifid_en = 1, then 3 DRAIN cycles, then HALTED; host_step and host_resume together -> RUN.
- ex_valid = wb_valid = wb_regwrite = 1, ex_rd = wb_rd = 3'd5 -> fwd_a = 1; wb_rd = 3'd4 -> fwd_a = 0; id_inst[5:3] = 3'd4 with id_valid = 1 -> id_bypass = 1.
- rst asserted mid-DRAIN (drain_cnt = 1) -> state immediately = 00, retired = 0, ifid_flush = 1 while rst is high.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl
// Sequencing and hazard controller for a 4-stage 8-bit pipeline (IF, ID, EX, WB).
// Resolves jumps in ID, handles HALT instructions and host halt/step/resume
// with a fixed drain period, selects EX forwarding and the ID register-file
// bypass, and counts retired instructions.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   host_halt_req/step/resume    host debug controls (level / pulse / pulse)
//   if_pc, id_pc                 PCs of the IF and ID instructions
//   id_valid, id_inst            IF/ID contents ([7:6] op, [5:3] rd, [5:0] imm)
//   ex_valid/ex_rd/ex_regwrite   ID/EX stage info
//   wb_valid/wb_rd/wb_regwrite   EX/WB stage info
//   pc_en, pc_load, pc_target    PC control (pc_load overrides pc_en)
//   ifid_en, ifid_flush          IF/ID control (flush wins over enable)
//   fwd_a, id_bypass             forwarding / bypass selects
//   halted, state                controller state (00 RUN 01 DRAIN 10 HALTED 11 STEP)
//   retired                      retired instruction count (wraps)
module pipe_seq_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter bit          START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_halt_req,
  input  logic        host_step,
  input  logic        host_resume,
  input  logic [7:0]  if_pc,
  input  logic [7:0]  id_pc,
  input  logic        id_valid,
  input  logic [7:0]  id_inst,
  input  logic        ex_valid,
  input  logic [2:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        wb_valid,
  input  logic [2:0]  wb_rd,
  input  logic        wb_regwrite,
  output logic        pc_en,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        fwd_a,
  output logic        id_bypass,
  output logic        halted,
  output logic [1:0]  state,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10,
    ST_STEP   = 2'b11
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);
  localparam state_t     RESET_STATE = START_HALTED ? ST_HALTED : ST_RUN;

  state_t      state_reg;
  logic [2:0]  drain_cnt_reg;
  logic [15:0] retired_reg;

  // Decode of the IF/ID instruction
  logic [7:0] pc_inc;
  logic [7:0] jtgt;
  logic       jmp;
  logic       hlt;

  // ex_regwrite is informational only: forwarding depends on the WB writer.
  logic       unused_ok;
  assign unused_ok = ex_regwrite;

  assign pc_inc = id_pc + 8'd1;
  // Jump stays within the 64-byte page of the following instruction.
  assign jtgt   = {pc_inc[7:6], id_inst[5:0]};
  assign jmp    = id_valid & (id_inst[7:6] == 2'b11);
  assign hlt    = id_valid & (id_inst[7:6] == 2'b10);

  // State machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RESET_STATE;
      drain_cnt_reg <= 3'd0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (hlt || host_halt_req) begin
            state_reg     <= ST_DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_reg == 3'd0) begin
            state_reg <= ST_HALTED;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - 3'd1;
          end
        end
        ST_HALTED: begin
          if (host_resume) begin
            state_reg <= ST_RUN;
          end else if (host_step) begin
            state_reg <= ST_STEP;
          end
        end
        ST_STEP: begin
          state_reg     <= ST_DRAIN;
          drain_cnt_reg <= DRAIN_LOAD;
        end
        default: state_reg <= RESET_STATE;
      endcase
    end
  end

  // Retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_reg <= 16'd0;
    end else if (wb_valid) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  // Combinational pipeline control
  always_comb begin
    pc_en      = 1'b0;
    pc_load    = 1'b0;
    pc_target  = pc_inc;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (rst) begin
      ifid_flush = 1'b1;
    end else begin
      case (state_reg)
        ST_RUN: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (jmp) begin
            // Jump target wins even if a host halt is pending.
            pc_load    = 1'b1;
            pc_target  = jtgt;
            ifid_flush = 1'b1;
          end else if (hlt) begin
            pc_load    = 1'b1;
            pc_target  = pc_inc;
            ifid_flush = 1'b1;
          end else if (host_halt_req) begin
            // Discard the fetched instruction; it is refetched on resume.
            pc_load    = 1'b1;
            pc_target  = if_pc;
            ifid_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          ifid_flush = 1'b1;
          if (jmp) begin
            pc_load   = 1'b1;
            pc_target = jtgt;
          end
        end
        ST_HALTED: begin
          ifid_flush = 1'b1;
        end
        ST_STEP: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
        default: ifid_flush = 1'b1;
      endcase
    end
  end

  // Forwarding and bypass
  assign fwd_a     = ~rst & ex_valid & wb_valid & wb_regwrite & (wb_rd == ex_rd);
  assign id_bypass = ~rst & id_valid & wb_valid & wb_regwrite & (wb_rd == id_inst[5:3]);

  assign halted  = (state_reg == ST_HALTED);
  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed testbench for pipe_seq_ctrl (DRAIN_CYCLES = 3, START_HALTED = 0).
module tb_pipe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_halt_req, host_step, host_resume;
  logic [7:0]  if_pc, id_pc, id_inst;
  logic        id_valid;
  logic        ex_valid, ex_regwrite, wb_valid, wb_regwrite;
  logic [2:0]  ex_rd, wb_rd;
  logic        pc_en, pc_load, ifid_en, ifid_flush, fwd_a, id_bypass, halted;
  logic [7:0]  pc_target;
  logic [1:0]  state;
  logic [15:0] retired;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.DRAIN_CYCLES(3), .START_HALTED(1'b0)) dut (
    .clk(clk), .rst(rst),
    .host_halt_req(host_halt_req), .host_step(host_step), .host_resume(host_resume),
    .if_pc(if_pc), .id_pc(id_pc), .id_valid(id_valid), .id_inst(id_inst),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_en(pc_en), .pc_load(pc_load), .pc_target(pc_target),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .id_bypass(id_bypass),
    .halted(halted), .state(state), .retired(retired)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    host_halt_req = 0; host_step = 0; host_resume = 0;
    if_pc = 0; id_pc = 0; id_inst = 0; id_valid = 0;
    ex_valid = 0; ex_rd = 0; ex_regwrite = 0;
    wb_valid = 0; wb_rd = 0; wb_regwrite = 0;

    // Reset state
    #1;
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_pc_en", 16'(pc_en), 16'h0);
    chk("rst_flush", 16'(ifid_flush), 16'h1);
    chk("rst_retired", retired, 16'h0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("run_state", 16'(state), 16'h0);
    chk("run_pc_en", 16'(pc_en), 16'h1);
    chk("run_flush", 16'(ifid_flush), 16'h0);
    chk("run_pc_load", 16'(pc_load), 16'h0);
    chk("run_retired", retired, 16'h0);

    // Four WB-valid edges
    wb_valid = 1;
    cyc(); cyc(); cyc(); cyc();
    wb_valid = 0;
    chk("retired4", retired, 16'd4);

    // Jump in RUN
    id_valid = 1; id_inst = 8'hC5; id_pc = 8'h7F;
    #1;
    chk("jmp_load", 16'(pc_load), 16'h1);
    chk("jmp_tgt", 16'(pc_target), 16'h85);
    chk("jmp_flush", 16'(ifid_flush), 16'h1);
    id_pc = 8'hFF;
    #1;
    chk("jmp_tgt_wrap", 16'(pc_target), 16'h05);
    id_valid = 0;
    #1;
    chk("jmp_invalid", 16'(pc_load), 16'h0);
    cyc();
    chk("jmp_stay_run", 16'(state), 16'h0);

    // HALT instruction -> DRAIN x3 -> HALTED
    id_valid = 1; id_inst = 8'h80; id_pc = 8'h10;
    #1;
    chk("hlt_load", 16'(pc_load), 16'h1);
    chk("hlt_tgt", 16'(pc_target), 16'h11);
    chk("hlt_flush", 16'(ifid_flush), 16'h1);
    cyc();
    id_valid = 0;
    #1;
    chk("drain1_state", 16'(state), 16'h1);
    chk("drain1_pc_en", 16'(pc_en), 16'h0);
    cyc();
    chk("drain2_state", 16'(state), 16'h1);
    cyc();
    chk("drain3_state", 16'(state), 16'h1);
    cyc();
    chk("halted_state", 16'(state), 16'h2);
    chk("halted_flag", 16'(halted), 16'h1);
    chk("halted_ifid_en", 16'(ifid_en), 16'h0);
    chk("halted_flush", 16'(ifid_flush), 16'h1);
    host_halt_req = 1;
    cyc();
    host_halt_req = 0;
    chk("halted_ignore_req", 16'(state), 16'h2);

    // Resume
    host_resume = 1;
    cyc();
    host_resume = 0;
    chk("resume_run", 16'(state), 16'h0);

    // Host halt request
    host_halt_req = 1; if_pc = 8'h22;
    #1;
    chk("hreq_load", 16'(pc_load), 16'h1);
    chk("hreq_tgt", 16'(pc_target), 16'h22);
    chk("hreq_flush", 16'(ifid_flush), 16'h1);
    cyc();
    host_halt_req = 0;
    chk("hreq_drain", 16'(state), 16'h1);
    // Jump still resolved in DRAIN, HALT ignored
    id_valid = 1; id_inst = 8'hC5; id_pc = 8'h7F;
    #1;
    chk("drain_jmp_load", 16'(pc_load), 16'h1);
    chk("drain_jmp_tgt", 16'(pc_target), 16'h85);
    chk("drain_jmp_pc_en", 16'(pc_en), 16'h0);
    id_inst = 8'h80;
    #1;
    chk("drain_hlt_ignored", 16'(pc_load), 16'h0);
    id_valid = 0;
    cyc(); cyc();
    chk("hreq_drain3", 16'(state), 16'h1);
    cyc();
    chk("hreq_halted", 16'(state), 16'h2);

    // Single step
    host_step = 1;
    cyc();
    host_step = 0;
    #1;
    chk("step_state", 16'(state), 16'h3);
    chk("step_pc_en", 16'(pc_en), 16'h1);
    chk("step_ifid_en", 16'(ifid_en), 16'h1);
    chk("step_flush", 16'(ifid_flush), 16'h0);
    cyc();
    chk("step_drain1", 16'(state), 16'h1);
    cyc(); cyc();
    chk("step_drain3", 16'(state), 16'h1);
    cyc();
    chk("step_halted", 16'(state), 16'h2);

    // Resume has priority over step
    host_step = 1; host_resume = 1;
    cyc();
    host_step = 0; host_resume = 0;
    chk("resume_prio", 16'(state), 16'h0);

    // Forwarding / bypass (no clock edge inside this block)
    ex_valid = 1; wb_valid = 1; wb_regwrite = 1; ex_rd = 3'd5; wb_rd = 3'd5;
    #1;
    chk("fwd_hit", 16'(fwd_a), 16'h1);
    wb_rd = 3'd4;
    #1;
    chk("fwd_miss", 16'(fwd_a), 16'h0);
    id_valid = 1; id_inst = 8'h20;
    #1;
    chk("byp_hit", 16'(id_bypass), 16'h1);
    id_valid = 0;
    #1;
    chk("byp_invalid", 16'(id_bypass), 16'h0);
    ex_valid = 0; wb_valid = 0; wb_regwrite = 0;
    chk("retired_still4", retired, 16'd4);

    // Reset mid-DRAIN (drain_cnt = 1)
    host_halt_req = 1; wb_valid = 1;
    cyc();
    host_halt_req = 0;
    cyc();
    wb_valid = 0;
    #1;
    chk("pre_rst_drain", 16'(state), 16'h1);
    chk("pre_rst_retired", retired, 16'd6);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_state", 16'(state), 16'h0);
    chk("mid_rst_retired", retired, 16'h0);
    chk("mid_rst_flush", 16'(ifid_flush), 16'h1);
    chk("mid_rst_pc_en", 16'(pc_en), 16'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_run", 16'(pc_en), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
